// File: rtl/synch_fifo_reader.sv
// synch_fifo_reader: drains a synchronous FIFO (1-cycle read latency) into a valid/ready stream
// through a 2-entry skid buffer, with burst-boundary marking and a sticky underflow flag.
module synch_fifo_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int CNT_W      = $clog2(BURST_LEN) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  output logic                  fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
  input  logic                  fifo_empty_i,
  input  logic                  fifo_underflow_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  output logic                  err_o
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;
  state_e                state_q, state_d;
  logic                  inflight_q, err_q, pop_out;
  logic [DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      beat_q, beat_d;
  logic [2:0]            level;
  always_comb begin
    m_valid_o = state_q != EMPTY;
    m_last_o = m_valid_o & (beat_q == CNT_W'(BURST_LEN - 1));
    pop_out = m_valid_o & m_ready_i;
    // Words already held or on their way, minus the one leaving this cycle, must leave room.
    level = {1'b0, state_q} + {2'b0, inflight_q} - {2'b0, pop_out};
    fifo_rd_en_o = rst & en_i & ~fifo_empty_i & (level < 3'd2);
    state_d = (inflight_q & ~pop_out) ? (state_q == EMPTY ? ONE : TWO) :
              (~inflight_q & pop_out) ? (state_q == TWO ? ONE : EMPTY) : state_q;
    head_d = (pop_out & state_q == TWO) ? tail_q :
             (inflight_q & (state_q == EMPTY | (state_q == ONE & pop_out))) ? fifo_rdata_i : head_q;
    tail_d = (inflight_q & ((state_q == ONE & ~pop_out) | (state_q == TWO & pop_out))) ? fifo_rdata_i : tail_q;
    beat_d = pop_out ? (m_last_o ? '0 : beat_q + 1'b1) : beat_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= EMPTY;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      beat_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_rd_en_o;
      head_q     <= head_d;
      tail_q     <= tail_d;
      beat_q     <= beat_d;
      err_q      <= err_q | fifo_underflow_i;
    end
  end
  assign m_data_o = head_q;
  assign err_o    = err_q;
endmodule

// File: tb/tb_synch_fifo_reader.sv
// tb_synch_fifo_reader: randomized bench with a behavioural FIFO and an in-order scoreboard
// whose burst markers come from a running count of delivered beats.
module tb_synch_fifo_reader;
  localparam int BL = 4;
  logic       clk, rst, en, ready;
  logic       rd_en, m_valid, m_last, err, underflow;
  logic [7:0] rdata, m_data;
  logic [7:0] mem [512];
  int         rp, wp, n_vec, n_bad, nbeat;
  logic       rd_s, useen;
  logic [7:0] exp_q [$];
  logic       o_v, o_hs, o_l, o_rd, o_e, o_r;
  logic [7:0] o_d;
  wire        fifo_empty = (rp == wp);

  synch_fifo_reader #(.DATA_WIDTH(8), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .en_i(en), .fifo_rd_en_o(rd_en), .fifo_rdata_i(rdata),
    .fifo_empty_i(fifo_empty), .fifo_underflow_i(underflow), .m_valid_o(m_valid),
    .m_ready_i(ready), .m_data_o(m_data), .m_last_o(m_last), .err_o(err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIFO: the pop request is sampled mid-cycle, data appears one edge later.
  always @(negedge clk) rd_s = rd_en;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rp <= wp;
      rdata <= 8'h00;
      underflow <= 1'b0;
    end else begin
      underflow <= rd_s && (rp == wp);
      if (rd_s && rp != wp) begin
        rdata <= mem[rp % 512];
        rp <= rp + 1;
      end
    end
  end
  always @(posedge clk) if (underflow) useen = 1'b1;

  function automatic logic exp_last();
    return (nbeat % BL) == BL - 1;
  endfunction

  task automatic push(input logic [7:0] d);
    mem[wp % 512] = d;
    wp = wp + 1;
    exp_q.push_back(d);
  endtask

  task automatic tick();
    @(negedge clk);
    o_v = m_valid; o_r = ready; o_hs = m_valid & ready; o_d = m_data;
    o_l = m_last; o_rd = rd_en; o_e = err;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      en = 1'($urandom); ready = 1'($urandom);
      mem[wp % 512] = 8'($urandom);
      wp = wp + 1;
      tick();
      n_vec++;
      if ({o_v, o_l, o_d, o_rd, o_e} !== 12'h0) begin
        n_bad++;
        $display("FAIL reset_outputs: valid=%b last=%b data=%h rd_en=%b err=%b, all required 0", o_v, o_l, o_d, o_rd, o_e);
      end
    end
    rst = 1'b1; en = 1'b0; ready = 1'b0;
    nbeat = 0;
  endtask

  task automatic test_stream();
    logic [7:0] ed;
    logic       el;
    en = 1'b1; ready = 1'b1;
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    for (int c = 0; c < 10; c++) begin
      tick();
      if (c == 0) begin
        n_vec++;
        if (o_rd !== 1'b1) begin n_bad++; $display("FAIL stream_first_pop: rd_en=%b, required 1", o_rd); end
      end
      if (c < 2) begin
        n_vec++;
        if (o_v !== 1'b0) begin n_bad++; $display("FAIL stream_latency: valid=%b in cycle %0d, required 0", o_v, c); end
      end else begin
        ed = 8'h10 + 8'(c - 2);
        el = ((c - 2) % BL) == BL - 1;
        n_vec++;
        if (o_hs !== 1'b1 || o_d !== ed || o_l !== el) begin
          n_bad++;
          $display("FAIL stream_beat: valid=%b data=%h last=%b, required 1 %h %b", o_v, o_d, o_l, ed, el);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        nbeat++;
      end
    end
  endtask

  task automatic test_en_pause();
    int pops, got;
    logic [7:0] ed;
    logic       el;
    en = 1'b1; ready = 1'b1; pops = 0; got = 0;
    for (int i = 0; i < 6; i++) push(8'h30 + 8'(i));
    for (int c = 0; c < 10 && pops < 3; c++) begin
      tick();
      if (o_rd) pops++;
      if (o_hs) begin
        got++; n_vec++;
        ed = exp_q.pop_front(); el = exp_last(); nbeat++;
        if (o_d !== ed || o_l !== el) begin n_bad++; $display("FAIL en_beat: data=%h last=%b, required %h %b", o_d, o_l, ed, el); end
      end
    end
    en = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_vec++;
      if (o_rd !== 1'b0) begin n_bad++; $display("FAIL en_no_pop: rd_en=%b while en_i=0, required 0", o_rd); end
      if (o_hs) begin
        got++; n_vec++;
        ed = exp_q.pop_front(); el = exp_last(); nbeat++;
        if (o_d !== ed || o_l !== el) begin n_bad++; $display("FAIL en_beat: data=%h last=%b, required %h %b", o_d, o_l, ed, el); end
      end
    end
    n_vec++;
    if (got !== 3) begin n_bad++; $display("FAIL en_drained: %0d words delivered while paused, required 3", got); end
    en = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      tick();
      if (o_hs) begin
        n_vec++;
        ed = exp_q.pop_front(); el = exp_last(); nbeat++;
        if (o_d !== ed || o_l !== el) begin n_bad++; $display("FAIL en_resume: data=%h last=%b, required %h %b", o_d, o_l, ed, el); end
      end
    end
    n_vec++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL en_timeout: %0d words left, required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int pops;
    logic [7:0] ed;
    logic       el;
    en = 1'b1; ready = 1'b0; pops = 0;
    for (int i = 0; i < 6; i++) push(8'h20 + 8'(i));
    for (int c = 0; c < 10; c++) begin
      tick();
      if (o_rd) pops++;
      if (c >= 2) begin
        n_vec++;
        if (o_v !== 1'b1 || o_d !== 8'h20) begin n_bad++; $display("FAIL bp_hold: valid=%b data=%h, required 1 20", o_v, o_d); end
      end
    end
    n_vec++;
    if (pops !== 2) begin n_bad++; $display("FAIL bp_pops: %0d pops under back-pressure, required 2", pops); end
    ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      tick();
      if (o_hs) begin
        n_vec++;
        ed = exp_q.pop_front(); el = exp_last(); nbeat++;
        if (o_d !== ed || o_l !== el) begin n_bad++; $display("FAIL bp_release: data=%h last=%b, required %h %b", o_d, o_l, ed, el); end
      end
    end
    n_vec++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL bp_timeout: %0d words left, required 0", exp_q.size()); end
  endtask

  task automatic test_random();
    int sent;
    logic       pv, pr, pl;
    logic [7:0] pd, ed;
    logic       el;
    en = 1'b1; sent = 0; pv = 1'b0; pr = 1'b1; pd = 8'h00; pl = 1'b0;
    for (int c = 0; c < 3000 && (sent < 100 || exp_q.size() > 0); c++) begin
      tick();
      if (pv && !pr) begin
        n_vec++;
        if (o_v !== 1'b1 || o_d !== pd || o_l !== pl) begin
          n_bad++;
          $display("FAIL rand_stable: valid=%b data=%h last=%b, required 1 %h %b", o_v, o_d, o_l, pd, pl);
        end
      end
      if (o_hs) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL rand_extra: data=%h delivered, no word expected", o_d);
        end else begin
          ed = exp_q.pop_front(); el = exp_last(); nbeat++;
          if (o_d !== ed || o_l !== el) begin n_bad++; $display("FAIL rand_beat: data=%h last=%b, required %h %b", o_d, o_l, ed, el); end
        end
      end
      pv = o_v; pr = o_r; pd = o_d; pl = o_l;
      ready = ($urandom % 3) != 0;
      if (sent < 100 && $urandom_range(0, 1) == 1)
        for (int k = $urandom_range(1, 3); k > 0 && sent < 100; k--) begin
          push(8'($urandom));
          sent++;
        end
    end
    n_vec++;
    if (exp_q.size() != 0 || sent != 100) begin n_bad++; $display("FAIL rand_timeout: %0d words left of %0d sent, required 0 of 100", exp_q.size(), sent); end
  endtask

  task automatic test_async_reset();
    int got;
    logic [7:0] ed;
    logic       el;
    en = 1'b1; ready = 1'b1;
    for (int i = 0; i < 6; i++) push(8'h50 + 8'(i));
    for (int c = 0; c < 20 && (nbeat % BL) != BL - 1; c++) begin
      tick();
      if (o_hs) begin
        n_vec++;
        ed = exp_q.pop_front(); el = exp_last(); nbeat++;
        if (o_d !== ed || o_l !== el) begin n_bad++; $display("FAIL ar_pre: data=%h last=%b, required %h %b", o_d, o_l, ed, el); end
      end
      if ((nbeat % BL) == BL - 1) ready = 1'b0;
    end
    ready = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    n_vec++;
    if (o_v !== 1'b1 || o_l !== 1'b1) begin n_bad++; $display("FAIL ar_setup: valid=%b last=%b, required 1 1", o_v, o_l); end
    #2;
    rst = 1'b0;
    #1;
    n_vec++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 8'h00) begin
      n_bad++;
      $display("FAIL ar_immediate: valid=%b last=%b data=%h, required 0 0 00", m_valid, m_last, m_data);
    end
    exp_q.delete();
    nbeat = 0;
    tick();
    rst = 1'b1; ready = 1'b1; got = 0;
    push(8'hA0);
    for (int c = 0; c < 10 && got == 0; c++) begin
      tick();
      if (o_hs) begin
        got = 1; n_vec++;
        ed = exp_q.pop_front(); el = exp_last(); nbeat++;
        if (o_d !== ed || o_l !== el) begin n_bad++; $display("FAIL ar_fresh: data=%h last=%b, required %h %b", o_d, o_l, ed, el); end
      end
    end
    n_vec++;
    if (got != 1) begin n_bad++; $display("FAIL ar_timeout: no word delivered after reset, required A0"); end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; ready = 1'b0;
    rp = 0; wp = 0; n_vec = 0; n_bad = 0; nbeat = 0; useen = 1'b0; rd_s = 1'b0;
    test_reset();
    test_stream();
    test_en_pause();
    test_backpressure();
    test_random();
    test_async_reset();
    tick();
    n_vec++;
    if (o_e !== 1'b0 || useen !== 1'b0) begin n_bad++; $display("FAIL err_clear: err=%b underflow_seen=%b, required 0 0", o_e, useen); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
